// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - FSM state encoding (IDLE / BURST) as plain localparam constants
//   - default configuration values and the counter widths derived from them
//   - slice_word(): pulls producer word i out of a packed producer data bus
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 120;
    localparam int DEF_STALL_MAX = 64;

    localparam int CNT_W   = $clog2(DEF_BURST_LEN);
    localparam int STALL_W = $clog2(DEF_STALL_MAX);

    // slice_word works on a bus wide enough for 8 producers of up to 64 bits,
    // so any legal NUM_REQ/DATA_W combination can share one helper.
    localparam int MAX_REQ     = 8;
    localparam int SLICE_MAX_W = 64;
    localparam int SLICE_BUS_W = MAX_REQ * SLICE_MAX_W;

    function automatic logic [SLICE_MAX_W-1:0] slice_word(
        input logic [SLICE_BUS_W-1:0] data,
        input int                     idx,
        input int                     width
    );
        logic [SLICE_BUS_W-1:0] shifted;
        shifted = data >> (idx * width);
        return shifted[SLICE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_arb_if.sv
// ---------------------------------------------------------------------------
// fifo_arb_if
// Bundles the producer handshake and the FIFO write-side signals.
//   req_valid/req_last/req_data : producers -> arbiter
//   req_grant/req_ack/abort     : arbiter -> producers
//   fifo_full                   : FIFO -> arbiter
//   fifo_data/fifo_w_en         : arbiter -> FIFO
// Modports: slave = arbiter side, master = producer/FIFO environment side.
// ---------------------------------------------------------------------------
interface fifo_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        abort;
    logic                      fifo_full;
    logic [DATA_W-1:0]         fifo_data;
    logic                      fifo_w_en;

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_grant, req_ack, abort, fifo_data, fifo_w_en
    );

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_grant, req_ack, abort, fifo_data, fifo_w_en
    );
endinterface

// File: rtl/fifo_arb_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority search.
//   req_i        : request vector
//   last_owner_i : index of the previous grant holder; search starts above it
//   pick_o       : one-hot winner (0 when nothing requests)
//   idx_o        : binary index of the winner
//   any_o        : at least one request is present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk last_owner+1, last_owner+2, ... wrapping, and keep the first hit.
    // The previous owner is visited last, which is what gives fairness.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_owner_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing the single write port of the async FIFO among
// NUM_REQ producers. Lives entirely in the write clock domain. One producer
// owns the port for a burst of up to BURST_LEN words; writes stall on full.
// Ports:
//   wclk : write-domain clock
//   rst  : synchronous, active-high reset
//   bus  : fifo_arb_if.slave (producer handshake + FIFO write side)
// Optional feature macro: FIFO_ARB_TIMEOUT_EN -- when defined, a burst that
// has been stalled on full for STALL_MAX cycles is aborted and abort[owner]
// pulses for one cycle. Without it abort is constant 0.
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int STALL_MAX = DEF_STALL_MAX
) (
    input logic       wclk,
    input logic       rst,
    fifo_arb_if.slave bus
);

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int CNT_BITS = $clog2(BURST_LEN);

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;

    logic [NUM_REQ-1:0]  pick;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic                in_burst;
    logic                owner_valid;
    logic                owner_last;
    logic                accept;
    logic                burst_end;
    logic                timeout;
    logic [DATA_W-1:0]   owner_word;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req_i       (bus.req_valid),
        .last_owner_i(last_owner_q),
        .pick_o      (pick),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    // Accept a word only from the owner, only while it is valid and the FIFO
    // has room. The burst closes on its last word or when the count would
    // reach BURST_LEN, so the counter never needs to hold BURST_LEN itself.
    always_comb begin
        in_burst    = (state_q == ST_BURST);
        owner_valid = bus.req_valid[owner_q];
        owner_last  = bus.req_last[owner_q];
        owner_word  = DATA_W'(slice_word(SLICE_BUS_W'(bus.req_data), int'(owner_q), DATA_W));
        accept      = in_burst & owner_valid & ~bus.fifo_full;
        burst_end   = accept & (owner_last | (count_q == CNT_BITS'(BURST_LEN - 1)));
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int STALL_BITS = $clog2(STALL_MAX);

    logic [STALL_BITS-1:0] stall_q, stall_d;
    logic                  stalling;

    // Only a full FIFO in front of a valid owner counts as a stall; bubbles
    // from the producer do not. Reaching STALL_MAX-1 while still stalled
    // means this is the STALL_MAX-th stall cycle and the burst is dropped.
    always_comb begin
        stalling = in_burst & owner_valid & bus.fifo_full;
        timeout  = stalling & (stall_q == STALL_BITS'(STALL_MAX - 1));
        stall_d  = stall_q;
        if (!in_burst || accept || timeout) begin
            stall_d = '0;
        end else if (stalling) begin
            stall_d = stall_q + STALL_BITS'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge wclk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // abort marks the owner whose burst timed out, for exactly that cycle.
    always_comb begin
        bus.abort = '0;
        if (timeout) begin
            bus.abort[owner_q] = 1'b1;
        end
    end
`else
    // Without the timeout feature a stalled burst waits forever. STALL_MAX is
    // still referenced so both builds share one parameter list; the compare is
    // constant-false for any legal value.
    assign timeout   = (STALL_MAX < 0);
    assign bus.abort = '0;
`endif

    // Arbitration and burst bookkeeping. IDLE spends exactly one cycle picking
    // the next owner; BURST counts accepted words and hands the port back on
    // burst end or timeout, remembering the owner for the next search.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        grant_d      = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BURST;
                    grant_d = pick;
                    owner_d = pick_idx;
                    count_d = '0;
                end
            end
            default: begin
                if (accept) begin
                    count_d = count_q + CNT_BITS'(1);
                end
                if (burst_end || timeout) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    count_d      = '0;
                end
            end
        endcase
    end

    // State registers; last_owner resets to the top index so the first
    // search after reset begins at producer 0.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            count_q      <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            grant_q      <= grant_d;
        end
    end

    // FIFO write side and producer acknowledge follow accept directly so a
    // word is written in the same cycle it is presented.
    always_comb begin
        bus.req_grant = grant_q;
        bus.fifo_w_en = accept;
        bus.fifo_data = accept ? owner_word : '0;
        bus.req_ack   = '0;
        if (accept) begin
            bus.req_ack[owner_q] = 1'b1;
        end
    end

endmodule
